// File: rtl/bus_protocol_target.sv
// bus_protocol_target: dValid/dAck byte-bus receiver feeding a ready/valid FIFO.
// Define BUS_TARGET_DATACHK_EN to require data to hold steady until the ack.
module bus_protocol_target #(
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dValid,
    input  logic [7:0]             data,
    output logic                   dAck,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [1:0]  DLY  = 2'(ACK_DELAY);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

    state_t        state;
    logic          dv_q;
    logic [1:0]    cnt;
    logic [7:0]    hold_reg;
    logic          hold_ok;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rise;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          data_bad;

    assign rise      = dValid && !dv_q;
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

`ifdef BUS_TARGET_DATACHK_EN
    assign data_bad = (state == WAIT || state == ACK) && hold_ok
                      && (data != hold_reg);
`else
    assign data_bad = 1'b0;
`endif

    assign push_req = (state == ACK) && hold_ok && !data_bad;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = push_req && ((level < FULL) || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            dv_q      <= 1'b1;
            cnt       <= '0;
            hold_reg  <= '0;
            hold_ok   <= 1'b0;
            dAck      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            dv_q      <= dValid;
            dAck      <= 1'b0;
            proto_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        hold_reg <= data;
                        hold_ok  <= 1'b1;
                        cnt      <= DLY;
                        if (ACK_DELAY == 0) begin
                            state <= ACK;
                            dAck  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!dValid) begin
                        proto_err <= 1'b1;
                        hold_ok   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        if (data_bad) begin
                            hold_ok   <= 1'b0;
                            proto_err <= 1'b1;
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == 2'd1) begin
                            state <= ACK;
                            dAck  <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (data_bad) proto_err <= 1'b1;
                    hold_ok <= 1'b0;
                    cnt     <= '0;
                    state   <= DONE;
                end
                DONE: begin
                    // cnt counts clocks past the ack; flag a late release once.
                    if (!dValid) begin
                        state <= IDLE;
                    end else begin
                        if (cnt == 2'd1) proto_err <= 1'b1;
                        if (cnt != 2'd2) cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= hold_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_protocol_target.sv
// tb_bus_protocol_target: randomized checks of bus_protocol_target
// against a timestamp-based transfer model and a byte queue.
module tb_bus_protocol_target;
    localparam int DEPTH = 4;
    localparam int D     = 1;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef BUS_TARGET_DATACHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dValid = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          out_ready = 1'b0;
    logic          dAck;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          overflow;
    logic          proto_err;

    always #5 clk = ~clk;

    bus_protocol_target #(.DEPTH(DEPTH), .ACK_DELAY(D)) dut (
        .clk(clk), .reset(reset), .dValid(dValid), .data(data),
        .dAck(dAck), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow),
        .proto_err(proto_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: transfer timeline measured in edges from the rise.
    int         cyc = 0;
    int         t_rise = 0;
    bit         busy = 0;
    bit         prev_dv = 1;
    bit         held_ok = 0;
    logic [7:0] held = 0;
    bit         mk_dack = 0;
    bit         mk_err = 0;
    bit         mk_ovf = 0;
    logic [7:0] mq[$];

    int         r_ack, r_ack_at, r_err, r_ov_at, r_dev;
    logic [7:0] r_ov_data;

    task automatic tick();
        bit dv, rdy, pop, pend, chk_edge, take;
        logic [7:0] d;
        int k;
        @(posedge clk);
        dv = dValid; d = data; rdy = out_ready;
        mk_dack = 0; mk_err = 0;
        if (!reset) begin
            busy = 0; prev_dv = 1; mk_ovf = 0; mq.delete();
        end else begin
            pop = (mq.size() != 0) && rdy;
            pend = 0; chk_edge = 0; take = 0;
            if (!busy) begin
                if (dv && !prev_dv) begin
                    busy = 1; t_rise = cyc; held = d; held_ok = 1;
                end
            end else begin
                k = cyc - t_rise;
                if (k <= D) begin
                    if (!dv) begin mk_err = 1; busy = 0; end
                    else chk_edge = 1;
                end else if (k == D + 1) begin
                    chk_edge = 1; pend = 1;
                end else if (!dv) begin
                    busy = 0;
                end else if (k == D + 3) begin
                    mk_err = 1;
                end
            end
            if (CHK && chk_edge && held_ok && d !== held) begin
                held_ok = 0; mk_err = 1;
            end
            if (busy && cyc - t_rise == D) mk_dack = 1;
            if (pend && held_ok) begin
                if (mq.size() < DEPTH || pop) take = 1;
                else mk_ovf = 1;
            end
            if (pop) void'(mq.pop_front());
            if (take) mq.push_back(held);
            prev_dv = dv;
        end
        cyc++;
        #1;
        if (dAck !== mk_dack || proto_err !== mk_err || overflow !== mk_ovf
            || level !== LW'(mq.size()) || out_valid !== (mq.size() != 0)
            || (mq.size() != 0 && out_data !== mq[0]))
            r_dev++;
    endtask

    task automatic do_reset();
        reset = 0; dValid = 0; out_ready = 0;
        tick(); tick();
        reset = 1;
        tick();
    endtask

    task automatic xfer(input logic [7:0] d, input int hold, input int chg,
                        input bit rnd, input int rdy_at);
        bit base;
        base = out_ready;
        r_ack = 0; r_ack_at = -1; r_err = 0; r_ov_at = -1; r_ov_data = 0;
        dValid = 0;
        if (rnd) out_ready = 1'($urandom);
        tick();
        dValid = 1; data = d;
        for (int i = 0; i < hold + 3; i++) begin
            if (i == hold) dValid = 0;
            if (i == chg) data = d ^ 8'h01;
            if (rnd) out_ready = 1'($urandom);
            else if (i == rdy_at) out_ready = 1;
            else out_ready = base;
            tick();
            if (dAck) begin r_ack++; r_ack_at = i + 1; end
            if (proto_err) r_err++;
            if (out_valid && r_ov_at < 0) begin
                r_ov_at = i + 1; r_ov_data = out_data;
            end
        end
    endtask

    task automatic test_reset();
        r_dev = 0;
        do_reset();
        checks++; if (dAck !== 1'b0) begin errors++; $display("FAIL reset_dack got=%b want=0", dAck); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", proto_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b want=0", out_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1; r_dev = 0;
        xfer(8'hA5, D + 2, -1, 0, -1);
        checks++; if (r_ack !== 1) begin errors++; $display("FAIL single_ack_cnt got=%0d want=1", r_ack); end
        checks++; if (r_ack_at !== D + 1) begin errors++; $display("FAIL single_ack_at got=%0d want=%0d", r_ack_at, D + 1); end
        checks++; if (r_ov_at !== D + 2) begin errors++; $display("FAIL single_ov_at got=%0d want=%0d", r_ov_at, D + 2); end
        checks++; if (r_ov_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h want=a5", r_ov_data); end
        checks++; if (r_err !== 0) begin errors++; $display("FAIL single_err got=%0d want=0", r_err); end
        checks++; if (level !== '0) begin errors++; $display("FAIL single_level got=%0d want=0", level); end
        checks++; if (r_dev !== 0) begin errors++; $display("FAIL single_model got=%0d want=0", r_dev); end
    endtask

    task automatic test_fill();
        do_reset();
        out_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            xfer(8'(i), D + 2, -1, 0, -1);
            checks++; if (r_ack !== 1) begin errors++; $display("FAIL fill_ack%0d got=%0d want=1", i, r_ack); end
            if (i == 4) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf4 got=%b want=0", overflow); end
            end
        end
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL fill_level got=%0d want=4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got=%b want=1", overflow); end
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_data !== 8'(i)) begin errors++; $display("FAIL fill_pop%0d got=%h want=%h", i, out_data, 8'(i)); end
            tick();
        end
        checks++; if (level !== '0) begin errors++; $display("FAIL fill_drain got=%0d want=0", level); end
    endtask

    task automatic test_full_pop();
        logic [7:0] b[5];
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) xfer(b[i], D + 2, -1, 0, -1);
        r_dev = 0;
        xfer(b[4], D + 2, -1, 0, D + 1);
        out_ready = 0;
        checks++; if (r_ack !== 1) begin errors++; $display("FAIL fullpop_ack got=%0d want=1", r_ack); end
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL fullpop_level got=%0d want=4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b want=0", overflow); end
        checks++; if (r_dev !== 0) begin errors++; $display("FAIL fullpop_model got=%0d want=0", r_dev); end
        out_ready = 1;
        for (int i = 1; i < 5; i++) begin
            checks++; if (out_data !== b[i]) begin errors++; $display("FAIL fullpop_order%0d got=%h want=%h", i, out_data, b[i]); end
            tick();
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        out_ready = 0; r_dev = 0;
        xfer(8'h5A, 1, -1, 0, -1);
        checks++; if (r_err !== 1) begin errors++; $display("FAIL early_err got=%0d want=1", r_err); end
        checks++; if (r_ack !== 0) begin errors++; $display("FAIL early_ack got=%0d want=0", r_ack); end
        checks++; if (level !== '0) begin errors++; $display("FAIL early_level got=%0d want=0", level); end
        checks++; if (r_dev !== 0) begin errors++; $display("FAIL early_model got=%0d want=0", r_dev); end
    endtask

    task automatic test_datachk();
        int exp_err;
        logic [LW-1:0] exp_lvl;
        exp_err = CHK ? 1 : 0;
        exp_lvl = CHK ? LW'(0) : LW'(1);
        do_reset();
        out_ready = 0; r_dev = 0;
        xfer(8'h3C, D + 2, 1, 0, -1);
        checks++; if (r_err !== exp_err) begin errors++; $display("FAIL chk_err got=%0d want=%0d", r_err, exp_err); end
        checks++; if (r_ack_at !== D + 1) begin errors++; $display("FAIL chk_ack_at got=%0d want=%0d", r_ack_at, D + 1); end
        checks++; if (level !== exp_lvl) begin errors++; $display("FAIL chk_level got=%0d want=%0d", level, exp_lvl); end
        checks++; if (r_dev !== 0) begin errors++; $display("FAIL chk_model got=%0d want=0", r_dev); end
    endtask

    task automatic test_late_release();
        do_reset();
        out_ready = 1; r_dev = 0;
        xfer(8'hC3, D + 6, -1, 0, -1);
        checks++; if (r_err !== 1) begin errors++; $display("FAIL late_err got=%0d want=1", r_err); end
        checks++; if (r_ack !== 1) begin errors++; $display("FAIL late_ack got=%0d want=1", r_ack); end
        checks++; if (r_dev !== 0) begin errors++; $display("FAIL late_model got=%0d want=0", r_dev); end
    endtask

    task automatic test_reset_mid();
        int acks;
        do_reset();
        out_ready = 0;
        dValid = 0; tick();
        dValid = 1; data = 8'h77; tick();
        reset = 0; tick();
        checks++; if (dAck !== 1'b0) begin errors++; $display("FAIL mid_dack got=%b want=0", dAck); end
        checks++; if (level !== '0) begin errors++; $display("FAIL mid_level got=%0d want=0", level); end
        reset = 1; acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dAck) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL mid_noack got=%0d want=0", acks); end
        checks++; if (level !== '0) begin errors++; $display("FAIL mid_level2 got=%0d want=0", level); end
        xfer(8'h78, D + 2, -1, 0, -1);
        checks++; if (r_ack !== 1) begin errors++; $display("FAIL mid_next_ack got=%0d want=1", r_ack); end
        checks++; if (out_data !== 8'h78) begin errors++; $display("FAIL mid_next_data got=%h want=78", out_data); end
    endtask

    task automatic test_random();
        int hold, chg, sel;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 3);
            hold = (sel == 0) ? 1 : (sel == 3) ? D + 5 : D + 2;
            chg = ($urandom_range(0, 3) == 0) ? 1 : -1;
            r_dev = 0;
            xfer(8'($urandom), hold, chg, 1, -1);
            checks++; if (r_dev !== 0) begin errors++; $display("FAIL rand%0d_model got=%0d want=0", n, r_dev); end
        end
        out_ready = 1;
        r_dev = 0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        checks++; if (level !== '0) begin errors++; $display("FAIL rand_drain got=%0d want=0", level); end
        checks++; if (r_dev !== 0) begin errors++; $display("FAIL rand_drain_model got=%0d want=0", r_dev); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_early_drop();
        test_datachk();
        test_late_release();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
